spi_msg_regfile: RTL and testbench
==================================

SPI_MSG_REGFILE -- requirements
Module: spi_msg_regfile

Interface
REQ-001 SHALL have parameter NR_RW_REGS, default 4, number of read/write registers.
REQ-002 SHALL have parameter NR_RO_REGS, default 12, number of read-only registers; NR_RW_REGS+NR_RO_REGS (NR_TOTAL) in 1..64.
REQ-003 SHALL have parameter REG_BYTES, default 4, register width in bytes, legal 1..4.
REQ-004 sysClk  input  1  single clock; all logic rising-edge.
REQ-005 usrReset_n  input  1  asynchronous, active-low reset.
REQ-006 rxValid  input  1  one-cycle pulse, rx holds a received byte.
REQ-007 rx  input  8  received byte.
REQ-008 frameEnd  input  1  one-cycle pulse, chip-select deasserted (transaction end).
REQ-009 tx  output  8  byte for the next SPI exchange, registered.
REQ-010 rwRegs1D  output  NR_RW_REGS*REG_BYTES*8  flattened RW registers, register n at bits [8*REG_BYTES*(n+1)-1 : 8*REG_BYTES*n].
REQ-011 roRegs1D  input  NR_RO_REGS*REG_BYTES*8  flattened RO register sources, same packing; RO index k maps to register NR_RW_REGS+k.
REQ-012 wrStrobe  output  NR_RW_REGS  one-cycle pulse per RW register on completed write.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 State advances, and tx updates, only at sysClk edges with rxValid=1 or frameEnd=1.
REQ-015 States: IDLE, STATUS, LEN, RDDATA, WRDATA.
REQ-016 Command byte in IDLE: 0x00 = status; 10iiiiii = read from index i; 11iiiiii = write from index i; anything else stays IDLE, tx <= 0xEE.
REQ-017 Status: IDLE -> STATUS, tx <= {4'h5, abortErr, oorErr, roWrErr, 1'b0}; sticky flags cleared at the same edge; next byte returns to IDLE.
REQ-018 Read/write command: latch index, go to LEN, tx <= 0x00; next byte is register count N, 0 treated as 1.
REQ-019 Read: LEN -> RDDATA, tx <= MS byte of register[index]; each further rxValid emits the next byte MS-first; after REG_BYTES bytes, index increments, wrapping NR_TOTAL-1 -> 0; after N*REG_BYTES bytes, return to IDLE, tx <= 0x00.
REQ-020 Write: LEN -> WRDATA; bytes shift MS-first into a REG_BYTES shadow; on the last byte of each register, commit the shadow atomically, index increments with same wrap, count decrements; after N registers, return to IDLE.
REQ-021 Commit to RW index n: register updated and wrStrobe[n] pulses one cycle after the final byte's edge; commit to RO index: discarded, roWrErr set.
REQ-022 Start index >= NR_TOTAL: oorErr set at the command edge; reads return 0x00 bytes, writes discard; index then wraps as REQ-019.
REQ-023 frameEnd in any state: return to IDLE, partial shadow discarded, tx <= 0x00; if in LEN/RDDATA/WRDATA with count not exhausted, abortErr set.
REQ-024 frameEnd and rxValid on the same edge: frameEnd wins, byte ignored.
REQ-025 Flag set and status clear on the same edge: set wins.
REQ-026 RW registers change only via REQ-020/021; partial writes never visible on rwRegs1D.

Reset
REQ-027 On usrReset_n low, asynchronously: state IDLE, all RW registers 0, shadow 0, count and index 0, flags 0, tx 0x00, wrStrobe 0, busy 0.
REQ-028 Reset mid-transaction aborts with no commit and no wrStrobe; abortErr stays 0.

Configuration
REQ-029 Macro SPI_MSG_RO_SNAPSHOT_EN defined: all RO registers captured into a snapshot at the command-byte edge, and a read burst returns coherent snapshot values.
REQ-030 Macro SPI_MSG_RO_SNAPSHOT_EN undefined: no snapshot storage; each RO register sampled live when its MS byte is loaded into tx, and remaining bytes come from that same sample.

Verification
REQ-031 Defaults, RW reg1=0x11223344; rx 0x81, 0x01, then 4 dummies -> tx 0x00, 0x11, 0x22, 0x33, 0x44, then 0x00; busy ends low.
REQ-032 rx 0xC2, 0x02, 0xAABBCCDD, 0x01020304 -> reg2=0xAABBCCDD, reg3=0x01020304; wrStrobe[2] then wrStrobe[3] one pulse each; no change before the final byte of each register.
REQ-033 rx 0xC3, 0x02, 8 data bytes -> reg3 written, index 4 (RO) discarded; then rx 0x00 -> tx 0x52; a second status read -> 0x50.
REQ-034 rx 0xC0, 0x01, 0xDE, 0xAD, then frameEnd -> reg0 unchanged, no wrStrobe, status 0x58.
REQ-035 rx 0xBF (index 63), 0x01 -> oorErr set, 4 bytes 0x00; with SPI_MSG_RO_SNAPSHOT_EN, changing roRegs1D mid-burst of 0x84,0x02 leaves returned bytes equal to the values at the command edge.
REQ-036 usrReset_n pulsed low during WRDATA -> all outputs to REQ-027 values immediately, no clock required.

Source files
------------

// File: rtl/spi_msg_regfile.sv
// spi_msg_regfile: byte-oriented SPI message decoder over a bank of RW and RO registers.
// Define SPI_MSG_RO_SNAPSHOT_EN to capture all RO registers at each command byte for coherent reads.
module spi_msg_regfile #(
  parameter int NR_RW_REGS = 4,
  parameter int NR_RO_REGS = 12,
  parameter int REG_BYTES  = 4
) (
  input  logic                                sysClk,
  input  logic                                usrReset_n,
  input  logic                                rxValid,
  input  logic [7:0]                          rx,
  input  logic                                frameEnd,
  output logic [7:0]                          tx,
  output logic [NR_RW_REGS*REG_BYTES*8-1:0]   rwRegs1D,
  input  logic [NR_RO_REGS*REG_BYTES*8-1:0]   roRegs1D,
  output logic [NR_RW_REGS-1:0]               wrStrobe,
  output logic                                busy
);
  localparam int NT = NR_RW_REGS + NR_RO_REGS;
  localparam int W = REG_BYTES * 8;
  localparam logic [6:0] NT7 = 7'(NT);
  localparam logic [6:0] NRW7 = 7'(NR_RW_REGS);
  localparam logic [2:0] LASTB = 3'(REG_BYTES - 1);

  typedef enum logic [2:0] {IDLE, STATUS, LEN, RDDATA, WRDATA} state_e;

  state_e state_q, state_d;
  logic [7:0] tx_q, tx_d, cnt_q, cnt_d;
  logic [5:0] idx_q, idx_d, idx_inc;
  logic [2:0] byte_q, byte_d;
  logic wr_q, wr_d;
  logic [W-1:0] shadow_q, shadow_d, rd_q, rd_d, sh_next, cur_val, nxt_val;
  logic abort_q, abort_d, oor_q, oor_d, rowr_q, rowr_d;
  logic [NR_RW_REGS-1:0] strobe_q, strobe_d;
  logic [NR_RW_REGS*W-1:0] rw_q;
  logic [NT*W-1:0] src;

`ifdef SPI_MSG_RO_SNAPSHOT_EN
  logic [NR_RO_REGS*W-1:0] snap_q;
  always_ff @(posedge sysClk or negedge usrReset_n)
    if (!usrReset_n) snap_q <= '0;
    else if (rxValid && !frameEnd && state_q == IDLE) snap_q <= roRegs1D;
  assign src = {snap_q, rw_q};
`else
  assign src = {roRegs1D, rw_q};
`endif

  assign idx_inc = ({1'b0, idx_q} >= NT7 - 7'd1) ? 6'd0 : idx_q + 6'd1;
  assign sh_next = (shadow_q << 8) | W'(rx);

  // Out-of-range indices match no register and read as zero.
  always_comb begin
    cur_val = '0;
    nxt_val = '0;
    for (int n = 0; n < NT; n++) begin
      if (idx_q == 6'(n)) cur_val = src[n*W +: W];
      if (idx_inc == 6'(n)) nxt_val = src[n*W +: W];
    end
  end

  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    byte_d = byte_q;
    wr_d = wr_q;
    shadow_d = shadow_q;
    rd_d = rd_q;
    abort_d = abort_q;
    oor_d = oor_q;
    rowr_d = rowr_q;
    strobe_d = '0;
    if (frameEnd) begin
      state_d = IDLE;
      tx_d = 8'h00;
      shadow_d = '0;
      byte_d = '0;
      cnt_d = '0;
      abort_d = abort_q | (state_q inside {LEN, RDDATA, WRDATA});
    end else if (rxValid) begin
      case (state_q)
        IDLE: begin
          if (rx == 8'h00) begin
            state_d = STATUS;
            tx_d = {4'h5, abort_q, oor_q, rowr_q, 1'b0};
            {abort_d, oor_d, rowr_d} = '0;
          end else if (rx[7]) begin
            state_d = LEN;
            tx_d = 8'h00;
            idx_d = rx[5:0];
            wr_d = rx[6];
            byte_d = '0;
            oor_d = oor_q | ({1'b0, rx[5:0]} >= NT7);
          end else tx_d = 8'hEE;
        end
        STATUS: begin
          state_d = IDLE;
          tx_d = 8'h00;
        end
        LEN: begin
          cnt_d = (rx == 8'h00) ? 8'd1 : rx;
          byte_d = '0;
          shadow_d = '0;
          state_d = wr_q ? WRDATA : RDDATA;
          tx_d = wr_q ? 8'h00 : cur_val[W-1 -: 8];
          rd_d = cur_val << 8;
        end
        RDDATA: begin
          if (byte_q == LASTB) begin
            idx_d = idx_inc;
            cnt_d = cnt_q - 8'd1;
            byte_d = '0;
            state_d = (cnt_q == 8'd1) ? IDLE : RDDATA;
            tx_d = (cnt_q == 8'd1) ? 8'h00 : nxt_val[W-1 -: 8];
            rd_d = nxt_val << 8;
          end else begin
            byte_d = byte_q + 3'd1;
            tx_d = rd_q[W-1 -: 8];
            rd_d = rd_q << 8;
          end
        end
        WRDATA: begin
          tx_d = 8'h00;
          if (byte_q == LASTB) begin
            for (int n = 0; n < NR_RW_REGS; n++) strobe_d[n] = (idx_q == 6'(n));
            rowr_d = rowr_q | ({1'b0, idx_q} >= NRW7 && {1'b0, idx_q} < NT7);
            idx_d = idx_inc;
            cnt_d = cnt_q - 8'd1;
            byte_d = '0;
            shadow_d = '0;
            state_d = (cnt_q == 8'd1) ? IDLE : WRDATA;
          end else begin
            byte_d = byte_q + 3'd1;
            shadow_d = sh_next;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sysClk or negedge usrReset_n)
    if (!usrReset_n) begin
      state_q <= IDLE;
      tx_q <= 8'h00;
      cnt_q <= '0;
      idx_q <= '0;
      byte_q <= '0;
      wr_q <= 1'b0;
      shadow_q <= '0;
      rd_q <= '0;
      abort_q <= 1'b0;
      oor_q <= 1'b0;
      rowr_q <= 1'b0;
      strobe_q <= '0;
      rw_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      byte_q <= byte_d;
      wr_q <= wr_d;
      shadow_q <= shadow_d;
      rd_q <= rd_d;
      abort_q <= abort_d;
      oor_q <= oor_d;
      rowr_q <= rowr_d;
      strobe_q <= strobe_d;
      for (int n = 0; n < NR_RW_REGS; n++) if (strobe_d[n]) rw_q[n*W +: W] <= sh_next;
    end

  assign tx = tx_q;
  assign rwRegs1D = rw_q;
  assign wrStrobe = strobe_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_spi_msg_regfile.sv
// tb_spi_msg_regfile: scoreboard bench driving random SPI transactions against a transaction-level model.
module tb_spi_msg_regfile;
  localparam int NRW = 4;
  localparam int NRO = 12;
  localparam int NT = NRW + NRO;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_valid = 1'b0;
  logic [7:0] rx = 8'h00;
  logic frame_end = 1'b0;
  logic [7:0] tx;
  logic [NRW*32-1:0] rw_regs;
  logic [NRO*32-1:0] ro_vec = '0;
  logic [NRW-1:0] wr_strobe;
  logic busy;

  spi_msg_regfile dut (
    .sysClk(clk), .usrReset_n(rst_n), .rxValid(rx_valid), .rx(rx), .frameEnd(frame_end),
    .tx(tx), .rwRegs1D(rw_regs), .roRegs1D(ro_vec), .wrStrobe(wr_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] tx;
    bit busy;
    bit cm;
    int idx;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  logic [7:0] dq[$];
  int errors = 0;
  int checks = 0;
  logic [31:0] m_rw[NRW];
  logic [NRO*32-1:0] m_snap = '0;
  bit m_abort = 0, m_oor = 0, m_rowr = 0;
  logic ev = 1'b0;
  logic [NRW*32-1:0] rw_img = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] regval(input int i);
    if (i >= NT) return 32'h0;
    if (i < NRW) return m_rw[i];
`ifdef SPI_MSG_RO_SNAPSHOT_EN
    return m_snap[(i-NRW)*32 +: 32];
`else
    return ro_vec[(i-NRW)*32 +: 32];
`endif
  endfunction

  function automatic int nxt(input int i);
    return (i >= NT - 1) ? 0 : i + 1;
  endfunction

  always @(posedge clk) ev <= rst_n && (rx_valid || frame_end);

  // Monitor: one scoreboard entry per processed byte/frame end; RW image follows expected commits.
  always @(negedge clk) begin
    logic [NRW-1:0] exp_strb;
    exp_t e;
    if (!rst_n) rw_img = '0;
    else begin
      exp_strb = '0;
      if (ev) begin
        chk("queue_nonempty", 128'(q.size() != 0), 128'(1));
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("tx", 128'(tx), 128'(e.tx));
          chk("busy", 128'(busy), 128'(e.busy));
          if (e.cm) begin
            rw_img[e.idx*32 +: 32] = e.val;
            exp_strb[e.idx] = 1'b1;
          end
        end
      end
      chk("wrStrobe", 128'(wr_strobe), 128'(exp_strb));
      chk("rwRegs", 128'(rw_regs), 128'(rw_img));
    end
  end

  task automatic issue(input bit v, input logic [7:0] b, input bit fe, input logic [7:0] etx,
                       input bit ebusy, input bit ecm = 0, input int eidx = 0, input logic [31:0] eval = 0);
    exp_t e;
    e.tx = etx; e.busy = ebusy; e.cm = ecm; e.idx = eidx; e.val = eval;
    q.push_back(e);
    rx_valid = v; rx = b; frame_end = fe;
    @(negedge clk);
    rx_valid = 1'b0; frame_end = 1'b0; rx = 8'($urandom);
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic cmd_byte(input logic [7:0] c, input logic [7:0] etx, input bit ebusy);
    m_snap = ro_vec;
    issue(1, c, 0, etx, ebusy);
  endtask

  task automatic fend(input bit aborted, input bit with_rx);
    if (aborted) m_abort = 1;
    issue(with_rx, 8'($urandom), 1, 8'h00, 0);
  endtask

  task automatic rd(input int start, input logic [7:0] len, input int k, input bit chg, input bit fe_rx);
    int total, idx;
    logic [31:0] cur;
    logic [7:0] etx;
    if (start >= NT) m_oor = 1;
    cmd_byte(8'h80 | 8'(start), 8'h00, 1);
    total = ((len == 0) ? 1 : int'(len)) * 4;
    idx = start;
    cur = regval(idx);
    issue(1, len, 0, cur[31:24], 1);
    for (int j = 1; j <= k; j++) begin
      if (chg && $urandom_range(0, 1) == 1) ro_vec[$urandom_range(0, NRO-1)*32 +: 32] = $urandom;
      if (j == total) etx = 8'h00;
      else if (j % 4 == 0) begin
        idx = nxt(idx);
        cur = regval(idx);
        etx = cur[31:24];
      end else etx = cur[8*(3 - j%4) +: 8];
      issue(1, 8'($urandom), 0, etx, j != total);
    end
    fend(k < total, fe_rx);
  endtask

  task automatic wr(input int start, input logic [7:0] len, input int k, input bit fe_rx);
    int total, idx, ci;
    logic [31:0] sh;
    logic [7:0] b;
    bit cm;
    if (start >= NT) m_oor = 1;
    cmd_byte(8'hC0 | 8'(start), 8'h00, 1);
    issue(1, len, 0, 8'h00, 1);
    total = ((len == 0) ? 1 : int'(len)) * 4;
    idx = start;
    sh = 0;
    for (int j = 1; j <= k; j++) begin
      b = (dq.size() != 0) ? dq.pop_front() : 8'($urandom);
      sh = {sh[23:0], b};
      cm = 0;
      ci = 0;
      if (j % 4 == 0) begin
        if (idx < NRW) begin
          m_rw[idx] = sh;
          cm = 1;
        end else if (idx < NT) m_rowr = 1;
        ci = idx;
        idx = nxt(idx);
      end
      issue(1, b, 0, 8'h00, j != total, cm, ci, sh);
    end
    fend(k < total, fe_rx);
  endtask

  task automatic status();
    logic [7:0] etx;
    etx = {4'h5, m_abort, m_oor, m_rowr, 1'b0};
    m_abort = 0; m_oor = 0; m_rowr = 0;
    cmd_byte(8'h00, etx, 1);
    issue(1, 8'($urandom), 0, 8'h00, 0);
    fend(0, 0);
  endtask

  task automatic invalid(input logic [7:0] c);
    cmd_byte(c, 8'hEE, 0);
    fend(0, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, start, len, total, k;
    foreach (m_rw[i]) m_rw[i] = '0;
    ro_vec = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    #1;
    chk("reset_tx", 128'(tx), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_strobe", 128'(wr_strobe), 128'(0));
    chk("reset_rw", 128'(rw_regs), 128'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dq = {8'h11, 8'h22, 8'h33, 8'h44};
    wr(1, 8'd1, 4, 0);
    rd(1, 8'd1, 4, 0, 0);
    dq = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
    wr(2, 8'd2, 8, 0);
    rd(2, 8'd2, 8, 0, 0);
    status();
    wr(3, 8'd2, 8, 0);
    status();
    status();
    wr(0, 8'd1, 2, 0);
    status();
    rd(63, 8'd1, 4, 0, 0);
    status();
    rd(4, 8'd2, 8, 1, 0);
    rd(15, 8'd2, 8, 0, 0);
    wr(1, 8'd0, 4, 0);
    invalid(8'h40);
    invalid(8'h01);
    fend(0, 1);
    for (int t = 0; t < 160; t++) begin
      kind = $urandom_range(0, 9);
      start = ($urandom_range(0, 7) == 0) ? $urandom_range(NT, 63) : $urandom_range(0, NT-1);
      len = $urandom_range(0, 3);
      total = ((len == 0) ? 1 : len) * 4;
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, total-1) : total;
      if (kind < 4) rd(start, 8'(len), k, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      else if (kind < 8) wr(start, 8'(len), k, $urandom_range(0, 1) == 1);
      else if (kind == 8) status();
      else invalid(8'($urandom_range(1, 127)));
    end
    status();
    // Reset mid-write: partial register must never land, abort must not be flagged.
    wr(0, 8'd1, 4, 0);
    cmd_byte(8'hC1, 8'h00, 1);
    issue(1, 8'h01, 0, 8'h00, 1);
    issue(1, 8'h5A, 0, 8'h00, 1);
    issue(1, 8'hA5, 0, 8'h00, 1);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_tx", 128'(tx), 128'(0));
    chk("async_reset_busy", 128'(busy), 128'(0));
    chk("async_reset_strobe", 128'(wr_strobe), 128'(0));
    chk("async_reset_rw", 128'(rw_regs), 128'(0));
    foreach (m_rw[i]) m_rw[i] = '0;
    m_abort = 0; m_oor = 0; m_rowr = 0; m_snap = '0;
    q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    status();
    rd(0, 8'd4, 16, 0, 0);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    chk("drain", 128'(q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
